// File: rtl/sd_frame_rx.sv
// ---------------------------------------------------------------------------
// sd_frame_rx
//   Serial frame receiver for the sen/sd upload link. Deframes MSB-first
//   frames made of an ADDR_W-bit address followed by a DATA_W-bit payload and
//   issues one single-cycle write per frame into a register bank with an
//   active-low write strobe. After NUM_FRAMES writes it raises done and
//   ignores the link until reset.
//
// Ports
//   clk        in   system clock, everything sampled on posedge
//   rst        in   asynchronous, active-high reset
//   en         in   receive enable, looked at only while waiting for a frame
//   sen        in   frame enable, active-low (1 = link idle)
//   sd         in   serial data, MSB first, valid while sen = 0
//   RB_RW      out  bank write strobe, 0 = write, 1 = read/idle
//   RB_A       out  bank address (received address field)
//   RB_D       out  bank write data (received payload field)
//   done       out  high once NUM_FRAMES writes have completed
//   frame_cnt  out  number of frames written so far
//   err_abort  out  sticky: sen rose before a frame was complete
//   err_ovr    out  sticky: sen stayed low past the last frame bit
//   err_seq    out  sticky: received address differed from frame_cnt
// ---------------------------------------------------------------------------
module sd_frame_rx #(
    parameter  int ADDR_W     = 3,
    parameter  int DATA_W     = 18,
    parameter  int NUM_FRAMES = 8,
    localparam int CW         = $clog2(NUM_FRAMES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sen,
    input  logic              sd,
    output logic              RB_RW,
    output logic [ADDR_W-1:0] RB_A,
    output logic [DATA_W-1:0] RB_D,
    output logic              done,
    output logic [CW-1:0]     frame_cnt,
    output logic              err_abort,
    output logic              err_ovr,
    output logic              err_seq
);

    localparam int FW = ADDR_W + DATA_W;
    localparam int BW = $clog2(FW + 1);

    // bitcnt value while the FW-th (last) bit of a frame is being sampled
    localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(NUM_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,   // waiting for sen to fall with en high
        S_SHIFT,  // collecting frame bits
        S_WRITE,  // one-cycle bank write in progress
        S_GAP,    // sen still low after a frame, waiting for it to rise
        S_DONE    // all frames landed, parked until reset
    } state_t;

    state_t state, state_next;

    logic [FW-1:0] shift;
    logic [BW-1:0] bitcnt;

    logic [FW-1:0] shift_in;
    logic [CW-1:0] cnt_inc;

    // Shifting left puts the first (MSB) bit of a frame at position FW-1
    // once all FW bits have arrived.
    assign shift_in = {shift[FW-2:0], sd};
    assign cnt_inc  = frame_cnt + 1'b1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so every path assigns
    // it; a missing assignment on some branch would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (en && !sen) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sen) begin
                    state_next = S_IDLE;
                end else if (bitcnt == LAST_BIT) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_inc == CNT_DONE) begin
                    state_next = S_DONE;
                end else if (!sen) begin
                    state_next = S_GAP;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (sen) begin
                    state_next = S_IDLE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs
    // -----------------------------------------------------------------------
    // The write strobe and bank address/data are loaded on the same edge that
    // samples the last frame bit, so RB_RW is low for exactly the cycle the
    // FSM spends in S_WRITE. The bank takes the write on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift     <= '0;
            bitcnt    <= '0;
            RB_RW     <= 1'b1;
            RB_A      <= '0;
            RB_D      <= '0;
            done      <= 1'b0;
            frame_cnt <= '0;
            err_abort <= 1'b0;
            err_ovr   <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // shift/bitcnt are only touched once a frame starts, so
                    // undriven sd while the link is idle cannot reach them
                    if (en && !sen) begin
                        shift  <= shift_in;
                        bitcnt <= BW'(1);
                    end
                end
                S_SHIFT: begin
                    if (sen) begin
                        // partial frame is simply abandoned
                        err_abort <= 1'b1;
                    end else begin
                        shift  <= shift_in;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            RB_RW <= 1'b0;
                            RB_A  <= shift_in[FW-1:DATA_W];
                            RB_D  <= shift_in[DATA_W-1:0];
                        end
                    end
                end
                S_WRITE: begin
                    RB_RW     <= 1'b1;
                    frame_cnt <= cnt_inc;
                    // write still lands at the received address; mismatch
                    // against the expected sequence number is only flagged
                    if (32'(RB_A) != 32'(frame_cnt)) begin
                        err_seq <= 1'b1;
                    end
                    // sen still low means extra bits beyond the frame; they
                    // are dropped while the FSM waits in S_GAP
                    if (!sen) begin
                        err_ovr <= 1'b1;
                    end
                    if (cnt_inc == CNT_DONE) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    // S_GAP and S_DONE leave every register unchanged
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_frame_rx.sv
module tb_sd_frame_rx;

    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 18;
    localparam int NUM_FRAMES = 8;
    localparam int FW         = ADDR_W + DATA_W;
    localparam int CW         = $clog2(NUM_FRAMES + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sen;
    logic              sd;
    logic              RB_RW;
    logic [ADDR_W-1:0] RB_A;
    logic [DATA_W-1:0] RB_D;
    logic              done;
    logic [CW-1:0]     frame_cnt;
    logic              err_abort;
    logic              err_ovr;
    logic              err_seq;

    sd_frame_rx #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_FRAMES(NUM_FRAMES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sen      (sen),
        .sd       (sd),
        .RB_RW    (RB_RW),
        .RB_A     (RB_A),
        .RB_D     (RB_D),
        .done     (done),
        .frame_cnt(frame_cnt),
        .err_abort(err_abort),
        .err_ovr  (err_ovr),
        .err_seq  (err_seq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Writes seen on the bank interface, and writes the model expects.
    logic [FW-1:0] wr_q[$];
    logic [FW-1:0] exp_q[$];

    // Reference model: frame-level bookkeeping only.
    int m_cnt;
    bit m_abort;
    bit m_ovr;
    bit m_seq;

    bit prev_low = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Bank-side monitor: capture every write, and a write strobe must never
    // stay low for two consecutive cycles.
    always @(negedge clk) begin
        if (rst) begin
            prev_low = 1'b0;
        end else if (RB_RW === 1'b0) begin
            wr_q.push_back({RB_A, RB_D});
            check("rw_pulse_width", 64'(prev_low), 64'(0));
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
    end

    task automatic drive(input logic s, input logic d);
        @(negedge clk);
        sen = s;
        sd  = d;
    endtask

    task automatic check_state(input string tag);
        logic [FW-1:0] last;
        last = '0;
        if (exp_q.size() > 0) last = exp_q[$];
        check({tag, "_cnt"},   64'(frame_cnt), 64'(m_cnt));
        check({tag, "_done"},  64'(done),      64'(m_cnt == NUM_FRAMES));
        check({tag, "_abort"}, 64'(err_abort), 64'(m_abort));
        check({tag, "_ovr"},   64'(err_ovr),   64'(m_ovr));
        check({tag, "_seq"},   64'(err_seq),   64'(m_seq));
        check({tag, "_rw"},    64'(RB_RW),     64'(1));
        check({tag, "_a"},     64'(RB_A),      64'(last[FW-1:DATA_W]));
        check({tag, "_d"},     64'(RB_D),      64'(last[DATA_W-1:0]));
        check({tag, "_nwr"},   64'(wr_q.size()), 64'(exp_q.size()));
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check({tag, "_wr"}, 64'(wr_q[i]), 64'(exp_q[i]));
        end
    endtask

    // Reset applied between clock edges; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        sen = 1'b1;
        sd  = 1'bx;
        en  = 1'b0;
        #1;
        check("rst_rw",    64'(RB_RW),     64'(1));
        check("rst_a",     64'(RB_A),      64'(0));
        check("rst_d",     64'(RB_D),      64'(0));
        check("rst_done",  64'(done),      64'(0));
        check("rst_cnt",   64'(frame_cnt), 64'(0));
        check("rst_errs",  64'({err_abort, err_ovr, err_seq}), 64'(0));
        m_cnt   = 0;
        m_abort = 1'b0;
        m_ovr   = 1'b0;
        m_seq   = 1'b0;
        wr_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Send a frame with sen held low for nlow cycles (short = aborted,
    // long = overrun with random trailing bits), then one sen=1 cycle.
    task automatic send(input logic [FW-1:0] frame, input int nlow, input logic en_v);
        bit exp_wr;
        exp_wr = en_v && (m_cnt != NUM_FRAMES) && (nlow >= FW);
        en = en_v;
        for (int i = 0; i < nlow; i++) begin
            drive(1'b0, (i < FW) ? frame[FW-1-i] : 1'($urandom));
            if (i == FW - 1) begin
                @(posedge clk);
                #1;
                check("lat_rw", 64'(RB_RW), 64'(!exp_wr));
                if (exp_wr) begin
                    check("lat_a", 64'(RB_A), 64'(frame[FW-1:DATA_W]));
                    check("lat_d", 64'(RB_D), 64'(frame[DATA_W-1:0]));
                end
            end
        end
        drive(1'b1, 1'bx);
        if (en_v && m_cnt != NUM_FRAMES) begin
            if (nlow < FW) begin
                m_abort = 1'b1;
            end else begin
                exp_q.push_back(frame);
                if (int'(frame[FW-1:DATA_W]) != m_cnt) m_seq = 1'b1;
                if (nlow > FW) m_ovr = 1'b1;
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check_state("frame");
    endtask

    function automatic logic [FW-1:0] mk(input int a, input int d);
        return {ADDR_W'(a), DATA_W'(d)};
    endfunction

    initial begin
        logic [FW-1:0] f;
        int            nlow;
        int            r;
        rst = 1'b1;
        en  = 1'b0;
        sen = 1'b1;
        sd  = 1'b0;

        // reset state
        do_reset();

        // 1: single frame, addr 0
        send(mk(0, 18'h2A5C3), FW, 1'b1);
        check_writes("t1");

        // 2: eight frames in order, one idle cycle between; a ninth is ignored
        do_reset();
        for (int i = 0; i < NUM_FRAMES; i++) begin
            send(mk(i, int'($urandom)), FW, 1'b1);
        end
        send(mk(0, 18'h12345), FW, 1'b1);
        check_writes("t2");

        // 3: aborted partial frame, then a full frame
        do_reset();
        send(mk(0, int'($urandom)), 10, 1'b1);
        send(mk(0, 18'h3FFFF), FW, 1'b1);
        check_writes("t3");

        // 4: overrun (23 low cycles), then a following frame is accepted
        do_reset();
        send(mk(0, int'($urandom)), FW + 2, 1'b1);
        send(mk(1, int'($urandom)), FW, 1'b1);
        check_writes("t4");

        // 5: out-of-sequence first address
        do_reset();
        send(mk(5, int'($urandom)), FW, 1'b1);
        check_writes("t5");

        // 6: reset at bit 12, then a normal frame, then a frame with en=0
        do_reset();
        f  = mk(0, int'($urandom));
        en = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b0, f[FW-1-i]);
        do_reset();
        check_writes("t6_rst");
        send(mk(0, 18'h0F0F0), FW, 1'b1);
        send(mk(1, 18'h15555), FW, 1'b0);
        check_writes("t6");

        // randomized frames: mostly good, some short/long/misaddressed/disabled
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int k = 0; k < 14; k++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)       nlow = FW;
                else if (r == 6) nlow = int'($urandom_range(1, FW - 1));
                else             nlow = FW + int'($urandom_range(1, 3));
                if ($urandom_range(0, 4) == 0) f = mk(int'($urandom), int'($urandom));
                else                           f = mk(m_cnt, int'($urandom));
                send(f, nlow, ($urandom_range(0, 7) != 0));
            end
            check_writes("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
